// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and the issue-stage decoder.
// The ALU imports the same package, so both ends agree on instruction layout.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        BSEL_RT   = 2'd0,
        BSEL_SEXT = 2'd1,
        BSEL_ZEXT = 2'd2
    } bsel_e;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       wen;
        bsel_e      bsel;
    } decode_t;

    // Non-writing instructions report dest = 0 so downstream never sees a stale index.
    function automatic decode_t decode(input logic [31:0] instr);
        decode_t d;
        d.rs   = instr[RS_HI:RS_LO];
        d.rt   = instr[RT_HI:RT_LO];
        d.dest = instr[RT_HI:RT_LO];
        d.wen  = 1'b0;
        d.bsel = BSEL_RT;
        case (instr[OP_HI:OP_LO])
            OP_RTYPE: begin
                d.dest = instr[RD_HI:RD_LO];
                d.wen  = 1'b1;
            end
            OP_ADDIU, OP_LW: begin
                d.bsel = BSEL_SEXT;
                d.wen  = 1'b1;
            end
            OP_ANDI: begin
                d.bsel = BSEL_ZEXT;
                d.wen  = 1'b1;
            end
            OP_SW:          d.bsel = BSEL_SEXT;
            OP_BEQ, OP_BNE: d.bsel = BSEL_RT;
            default:        d.bsel = BSEL_RT;
        endcase
        if (d.dest == 5'd0) d.wen = 1'b0;
        if (!d.wen) d.dest = 5'd0;
        return d;
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file with two combinational read ports and one write port.
// $0 always reads zero; a write in flight is bypassed to readers in the same cycle.
module reg_file_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra0,
    output logic [XLEN-1:0] rd0,
    input  logic [4:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0) regs_d[wa] = wd;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd0 = (ra0 == 5'd0) ? '0 : ((we && wa == ra0) ? wd : regs_q[ra0]);
    assign rd1 = (ra1 == 5'd0) ? '0 : ((we && wa == ra1) ? wd : regs_q[ra1]);

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage feeding the ALU input register. Operands come from a local register
// file; a busy-bit scoreboard holds RAW/WAW hazards until the producer writes back.
module id_issue_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     Instruction,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [4:0]      shamt,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      dest,
    output logic            dest_wen,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid and the operand outputs stay stable until out_ready or flush retires them.

    decode_t         dec;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] b_val;
    logic [15:0]     imm;

    assign dec = decode(in_instr);
    assign imm = in_instr[IMM_HI:IMM_LO];

    reg_file_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra0   (dec.rs),
        .rd0   (rs_val),
        .ra1   (dec.rt),
        .rd1   (rt_val),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    always_comb begin
        b_val = rt_val;
        case (dec.bsel)
            BSEL_SEXT: b_val = {{(XLEN-16){imm[15]}}, imm};
            BSEL_ZEXT: b_val = {{(XLEN-16){1'b0}}, imm};
            default:   b_val = rt_val;
        endcase
    end

    logic [NREGS-1:0] busy_q, busy_d, busy_eff, wb_mask;
    logic             stall, accept;

    logic            out_valid_q, out_valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      shamt_q, shamt_d;
    logic [XLEN-1:0] store_q, store_d;
    logic [4:0]      dest_q, dest_d;
    logic            dest_wen_q, dest_wen_d;

    always_comb begin
        wb_mask = '0;
        if (wb_en) wb_mask[wb_addr] = 1'b1;
    end

    // A register being written back this cycle is already safe to read through the bypass.
    assign busy_eff = busy_q & ~wb_mask;
    assign stall    = in_valid & (busy_eff[dec.rs] | busy_eff[dec.rt] |
                                  (dec.wen & busy_eff[dec.dest]));
    assign in_ready = (!out_valid_q | out_ready) & !stall & !flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        a_d         = a_q;
        b_d         = b_q;
        shamt_d     = shamt_q;
        store_d     = store_q;
        dest_d      = dest_q;
        dest_wen_d  = dest_wen_q;
        busy_d      = busy_q & ~wb_mask;

        if (flush && out_valid_q && dest_wen_q) busy_d[dest_q] = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            instr_d     = in_instr;
            a_d         = rs_val;
            b_d         = b_val;
            shamt_d     = in_instr[SH_HI:SH_LO];
            store_d     = rt_val;
            dest_d      = dec.dest;
            dest_wen_d  = dec.wen;
            if (dec.wen) busy_d[dec.dest] = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            shamt_q     <= '0;
            store_q     <= '0;
            dest_q      <= '0;
            dest_wen_q  <= 1'b0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            shamt_q     <= shamt_d;
            store_q     <= store_d;
            dest_q      <= dest_d;
            dest_wen_q  <= dest_wen_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign Instruction = instr_q;
    assign A           = a_q;
    assign B           = b_q;
    assign shamt       = shamt_q;
    assign store_data  = store_q;
    assign dest        = dest_q;
    assign dest_wen    = dest_wen_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed scenarios plus random traffic against a
// register-array/outstanding-write reference model, with a queue-based output scoreboard.
module tb_id_issue_stage;

  localparam int W = 139;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instruction;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [31:0] store_data;
  logic [4:0]  dest;
  logic        dest_wen;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;

  id_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .Instruction(Instruction), .A(A), .B(B), .shamt(shamt),
    .store_data(store_data), .dest(dest), .dest_wen(dest_wen),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           vectors;
  int           miscompares;

  // ---------------- reference model ----------------
  logic [31:0] mregs [32];
  logic [31:0] mbusy;
  logic [4:0]  wb_pend[$];
  logic        slot_valid;
  logic [4:0]  slot_dest;
  logic        slot_wen;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mbusy = 32'd0;
    wb_pend.delete();
    exp_q.delete();
    slot_valid = 1'b0;
    slot_dest  = 5'd0;
    slot_wen   = 1'b0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wa == r) return wd;
    return mregs[r];
  endfunction

  // Destination, write flag and B operand straight from the instruction-set rules.
  task automatic mdecode(input logic [31:0] ins, input logic [31:0] rtv,
                         output logic [4:0] dst, output logic wen, output logic [31:0] bv);
    logic [15:0] imm;
    imm = ins[15:0];
    dst = ins[20:16];
    wen = 1'b0;
    bv  = rtv;
    case (ins[31:26])
      6'd0:  begin dst = ins[15:11]; wen = 1'b1; end
      6'd9:  begin bv = 32'($signed(imm)); wen = 1'b1; end
      6'd35: begin bv = 32'($signed(imm)); wen = 1'b1; end
      6'd12: begin bv = 32'(imm); wen = 1'b1; end
      6'd43: bv = 32'($signed(imm));
      default: bv = rtv;
    endcase
    if (dst == 5'd0) wen = 1'b0;
    if (!wen) dst = 5'd0;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       output logic acc);
    logic [4:0]  rs, rt, dst;
    logic        wen, haz, exp_rdy, consumed, flushed;
    logic [31:0] bsy, av, rtv, bv;
    in_valid  = iv;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    wb_en     = we;
    wb_addr   = wa;
    wb_data   = wd;
    @(negedge clk);
    rs  = ins[25:21];
    rt  = ins[20:16];
    av  = mread(rs, we, wa, wd);
    rtv = mread(rt, we, wa, wd);
    mdecode(ins, rtv, dst, wen, bv);
    bsy = mbusy;
    if (we) bsy[wa] = 1'b0;
    haz     = iv && (bsy[rs] || bsy[rt] || (wen && bsy[dst]));
    exp_rdy = (!slot_valid || ordy) && !haz && !fl;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, slot_valid);
    chk("busy", dut.busy_q, mbusy);
    acc = iv && exp_rdy;
    if (acc) exp_q.push_back({ins, av, bv, ins[10:6], rtv, dst, wen});
    consumed = slot_valid && ordy && !fl;
    flushed  = slot_valid && fl;
    if (we) begin
      if (wa != 5'd0) mregs[wa] = wd;
      mbusy[wa] = 1'b0;
      for (int i = wb_pend.size() - 1; i >= 0; i--)
        if (wb_pend[i] == wa) wb_pend.delete(i);
    end
    if (flushed && slot_wen) mbusy[slot_dest] = 1'b0;
    if (consumed && slot_wen) wb_pend.push_back(slot_dest);
    if (acc) begin
      slot_valid = 1'b1;
      slot_dest  = dst;
      slot_wen   = wen;
      if (wen) mbusy[dst] = 1'b1;
    end else if (consumed || flushed) begin
      slot_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    logic a;
    for (int k = 0; k < n; k++) begin
      if (wb_pend.size() > 0) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, wb_pend[0], $urandom, a);
      else                    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, a);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: op = 6'd0;
      1: op = 6'd9;
      2: op = 6'd12;
      3: op = 6'd35;
      4: op = 6'd43;
      5: op = 6'd4;
      6: op = 6'd5;
      default: op = 6'h3F;
    endcase
    if (op == 6'd0) return rtype(rs, rt, rd, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
    return itype(op, rs, rt, 16'($urandom));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got instr %h with no expected entry at %0t",
                 Instruction, $time);
      end else begin
        chk("operands", {Instruction, A, B, shamt, store_data, dest, dest_wen}, exp_q[0]);
        if (out_ready || flush) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        acc;
    logic        have, ordy, fl, we;
    logic [4:0]  wa;
    logic [31:0] wd, cur;
    logic [31:0] i_addu8, i_addu9;

    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b0;
    flush     = 1'b0;
    wb_en     = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {Instruction, A, B, shamt, store_data, dest, dest_wen}, '0);
    chk("rst_busy", dut.busy_q, 32'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // addiu $1,$0,0x8001
    cycle(1'b1, itype(6'd9, 5'd0, 5'd1, 16'h8001), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_A", A, 32'd0);
    chk("t1_B", B, 32'hFFFF8001);
    chk("t1_dest", dest, 5'd1);
    chk("t1_dest_wen", dest_wen, 1'b1);
    chk("t1_busy1", dut.busy_q[1], 1'b1);

    // andi $2,$1,0xF0F0: RAW stall until $1 writes back
    cycle(1'b1, itype(6'd12, 5'd1, 5'd2, 16'hF0F0), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("t2_stall", in_ready, 1'b0);
    cycle(1'b1, itype(6'd12, 5'd1, 5'd2, 16'hF0F0), 1'b1, 1'b0, 1'b1, 5'd1, 32'h1234, acc);
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_A", A, 32'h1234);
    chk("t2_B", B, 32'h0000F0F0);

    // addu $3,$4,$5 held under backpressure
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0FB7AFF0, acc);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hA00D0FF0, acc);
    cycle(1'b1, rtype(5'd4, 5'd5, 5'd3, 5'd0, 6'h21), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, rtype(5'd0, 5'd4, 5'd6, 5'd2, 6'h00), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
      chk("t3_in_ready", in_ready, 1'b0);
      chk("t3_A", A, 32'h0FB7AFF0);
      chk("t3_B", B, 32'hA00D0FF0);
    end
    // sll $6,$4,2 released by out_ready
    cycle(1'b1, rtype(5'd0, 5'd4, 5'd6, 5'd2, 6'h00), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("t4_shamt", shamt, 5'd2);
    chk("t4_sll_B", B, 32'h0FB7AFF0);
    // sw $4,8($5)
    cycle(1'b1, itype(6'd43, 5'd5, 5'd4, 16'd8), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("t4_sw_wen", dest_wen, 1'b0);
    chk("t4_sw_B", B, 32'd8);
    chk("t4_sw_store", store_data, 32'h0FB7AFF0);
    chk("t4_sw_busy", dut.busy_q, mbusy);
    drain(6);

    // lw $7 then flush
    cycle(1'b1, itype(6'd35, 5'd1, 5'd7, 16'd4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("t5_busy7_set", dut.busy_q[7], 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
    chk("t5_flush_valid", out_valid, 1'b0);
    chk("t5_busy7_clr", dut.busy_q[7], 1'b0);
    i_addu8 = rtype(5'd7, 5'd7, 5'd8, 5'd0, 6'h21);
    cycle(1'b1, i_addu8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("t5_no_stall", Instruction, i_addu8);
    drain(4);

    // $0 stays zero and never blocks
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, acc);
    cycle(1'b1, itype(6'd9, 5'd0, 5'd0, 16'h0005), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("t6_dest_wen", dest_wen, 1'b0);
    chk("t6_A", A, 32'd0);
    i_addu9 = rtype(5'd0, 5'd0, 5'd9, 5'd0, 6'h21);
    cycle(1'b1, i_addu9, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("t6_no_stall", Instruction, i_addu9);
    chk("t6_A0", A, 32'd0);
    drain(4);

    // random traffic
    have = 1'b0;
    cur  = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        cur  = rand_instr();
        have = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      fl   = !ordy && ($urandom_range(0, 11) == 0);
      we   = 1'b0;
      wa   = 5'd0;
      wd   = $urandom;
      if (wb_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        we = 1'b1;
        wa = wb_pend[$urandom_range(0, wb_pend.size() - 1)];
      end else if ($urandom_range(0, 31) == 0) begin
        we = 1'b1;
      end
      cycle(have, cur, ordy, fl, we, wa, wd, acc);
      if (acc) have = 1'b0;
    end

    // asynchronous reset with work in flight
    cycle(1'b1, itype(6'd9, 5'd0, 5'd3, 16'h0042), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    in_valid = 1'b0;
    wb_en    = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    #2;
    model_reset();
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_busy", dut.busy_q, 32'd0);
    chk("arst_A", A, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, rtype(5'd3, 5'd4, 5'd10, 5'd0, 6'h21), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
    chk("arst_regs_cleared", {A, B}, 64'd0);
    drain(6);

    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
